// File: rtl/phase_pkg.sv
// Shared phase codes, FSM encoding and default window bases for the phase
// encoder/decoder pair.
package phase_pkg;

  localparam int unsigned COUNT_W = 8;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned SUM_W   = COUNT_W + 1;

  typedef enum logic [PHASE_W-1:0] {
    PH_READY = 2'd0,
    PH_RUN   = 2'd1,
    PH_BRAKE = 2'd2,
    PH_STOP  = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [COUNT_W-1:0] DEF_READY_BASE = 8'd0;
  localparam logic [COUNT_W-1:0] DEF_RUN_BASE   = 8'd64;
  localparam logic [COUNT_W-1:0] DEF_BRAKE_BASE = 8'd128;
  localparam logic [COUNT_W-1:0] DEF_STOP_BASE  = 8'd192;

  // Last count of a window; saturates at the top of the count range.
  function automatic logic [COUNT_W-1:0] window_end(input logic [COUNT_W-1:0] base,
                                                    input int unsigned span);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, base} + SUM_W'(span) - SUM_W'(1);
    return sum[COUNT_W] ? '1 : sum[COUNT_W-1:0];
  endfunction

endpackage

// File: rtl/step_tick.sv
// Divide-by-DIV tick generator with synchronous clear and enable.
module step_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_q;

  assign tick_c = en && (div_q == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div_q <= '0;
    end else if (en) begin
      div_q <= tick_c ? '0 : div_q + CW'(1);
    end
  end

endmodule

// File: rtl/phase_count_encoder.sv
// Sweeps the 8-bit count through the window of a requested phase, then
// pulses done (qualified by aborted when the sweep was cut short).
module phase_count_encoder
  import phase_pkg::*;
#(
  parameter logic [COUNT_W-1:0] READY_BASE = DEF_READY_BASE,
  parameter logic [COUNT_W-1:0] RUN_BASE   = DEF_RUN_BASE,
  parameter logic [COUNT_W-1:0] BRAKE_BASE = DEF_BRAKE_BASE,
  parameter logic [COUNT_W-1:0] STOP_BASE  = DEF_STOP_BASE,
  parameter int unsigned        SPAN       = 64,
  parameter int unsigned        STEP_DIV   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [PHASE_W-1:0] req_phase,
  output logic               req_ready,
  input  logic               abort,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  state_e             state_q, state_n;
  logic [COUNT_W-1:0] count_n;
  logic [COUNT_W-1:0] end_q, end_n;
  logic               accept_c;
  logic               abort_hit_c;
  logic               tick_c;

  function automatic logic [COUNT_W-1:0] base_of(input logic [PHASE_W-1:0] p);
    logic [COUNT_W-1:0] b;
    case (phase_e'(p))
      PH_READY: b = READY_BASE;
      PH_RUN:   b = RUN_BASE;
      PH_BRAKE: b = BRAKE_BASE;
      default:  b = STOP_BASE;
    endcase
    return b;
  endfunction

  step_tick #(
    .DIV (STEP_DIV)
  ) u_step_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept_c),
    .en     (state_q == ST_SWEEP),
    .tick_c (tick_c)
  );

  // Next state and count datapath; abort outranks the step tick.
  always_comb begin
    state_n     = state_q;
    count_n     = count;
    end_n       = end_q;
    accept_c    = 1'b0;
    abort_hit_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          count_n  = base_of(req_phase);
          end_n    = window_end(base_of(req_phase), SPAN);
          state_n  = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (abort) begin
          abort_hit_c = 1'b1;
          state_n     = ST_DONE;
        end else if (tick_c) begin
          if (count == end_q) begin
            state_n = ST_DONE;
          end else begin
            count_n = count + COUNT_W'(1);
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are flopped from the next-state decode so they align with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count     <= '0;
      end_q     <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state_q   <= state_n;
      count     <= count_n;
      end_q     <= end_n;
      req_ready <= (state_n == ST_IDLE);
      busy      <= (state_n != ST_IDLE);
      done      <= (state_n == ST_DONE);
      aborted   <= (state_n == ST_DONE) && abort_hit_c;
    end
  end

endmodule
